mmu_req_arbiter: RTL and testbench

- Shares the single MMU logic-request port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Keeps an in-order tag FIFO so each MMU response goes back to the requester that issued it.
- Sequences TLB flushes: blocks new grants, drains all outstanding accesses, then pulses the MMU TLB-flash line.
- Sits between the core pipeline ports and the mmu block.

---
 rtl/mmu_req_arbiter_pkg.sv | 21 ++
 rtl/mmu_req_arbiter_if.sv | 63 ++++++
 rtl/mmu_arb_tag_fifo.sv | 58 +++++
 rtl/mmu_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_mmu_req_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_req_arbiter_pkg.sv
// Shared constants and types for the MMU request arbiter: source tags, FSM
// state encodings and the fixed instruction-fetch access order.
package mmu_req_arbiter_pkg;

    localparam logic ARB_TAG_IF = 1'b0;
    localparam logic ARB_TAG_LS = 1'b1;

    localparam logic [1:0] ARB_STT_RUN   = 2'h0;
    localparam logic [1:0] ARB_STT_DRAIN = 2'h1;
    localparam logic [1:0] ARB_STT_FLASH = 2'h2;

    // Instruction fetch is always a word access
    localparam logic [1:0] ARB_IF_ORDER = 2'h2;

    typedef enum logic [1:0] {
        STT_RUN   = ARB_STT_RUN,
        STT_DRAIN = ARB_STT_DRAIN,
        STT_FLASH = ARB_STT_FLASH
    } arb_state_e;

endpackage

// File: rtl/mmu_req_arbiter_if.sv
// Bundle of requester, MMU and flush signals around the arbiter.
// slave = arbiter view, master = surrounding core/MMU view.
interface mmu_req_arbiter_if;

    logic        iIF_REQ;
    logic        oIF_LOCK;
    logic [1:0]  iIF_MODE;
    logic [31:0] iIF_PDT;
    logic [31:0] iIF_ADDR;
    logic        oIF_VALID;

    logic        iLS_REQ;
    logic        oLS_LOCK;
    logic        iLS_DATA_STORE_ACK;
    logic [1:0]  iLS_MODE;
    logic [31:0] iLS_PDT;
    logic [1:0]  iLS_ORDER;
    logic        iLS_RW;
    logic [31:0] iLS_ADDR;
    logic [31:0] iLS_DATA;
    logic        oLS_VALID;

    logic [63:0] oRESP_DATA;
    logic        iTLB_FLUSH_REQ;
    logic        oTLB_FLUSH_DONE;

    logic        oMMU_REQ;
    logic        oMMU_DATA_STORE_ACK;
    logic [1:0]  oMMU_MODE;
    logic [31:0] oMMU_PDT;
    logic [1:0]  oMMU_ORDER;
    logic        oMMU_RW;
    logic [31:0] oMMU_ADDR;
    logic [31:0] oMMU_DATA;
    logic        iMMU_LOCK;
    logic        oMMU_TLB_FLASH;
    logic        iMMU_VALID;
    logic [63:0] iMMU_DATA;
    logic        oPROTOCOL_ERR;

    modport slave (
        input  iIF_REQ, iIF_MODE, iIF_PDT, iIF_ADDR,
        input  iLS_REQ, iLS_DATA_STORE_ACK, iLS_MODE, iLS_PDT, iLS_ORDER,
        input  iLS_RW, iLS_ADDR, iLS_DATA,
        input  iTLB_FLUSH_REQ, iMMU_LOCK, iMMU_VALID, iMMU_DATA,
        output oIF_LOCK, oIF_VALID, oLS_LOCK, oLS_VALID, oRESP_DATA,
        output oTLB_FLUSH_DONE, oMMU_REQ, oMMU_DATA_STORE_ACK, oMMU_MODE,
        output oMMU_PDT, oMMU_ORDER, oMMU_RW, oMMU_ADDR, oMMU_DATA,
        output oMMU_TLB_FLASH, oPROTOCOL_ERR
    );

    modport master (
        output iIF_REQ, iIF_MODE, iIF_PDT, iIF_ADDR,
        output iLS_REQ, iLS_DATA_STORE_ACK, iLS_MODE, iLS_PDT, iLS_ORDER,
        output iLS_RW, iLS_ADDR, iLS_DATA,
        output iTLB_FLUSH_REQ, iMMU_LOCK, iMMU_VALID, iMMU_DATA,
        input  oIF_LOCK, oIF_VALID, oLS_LOCK, oLS_VALID, oRESP_DATA,
        input  oTLB_FLUSH_DONE, oMMU_REQ, oMMU_DATA_STORE_ACK, oMMU_MODE,
        input  oMMU_PDT, oMMU_ORDER, oMMU_RW, oMMU_ADDR, oMMU_DATA,
        input  oMMU_TLB_FLASH, oPROTOCOL_ERR
    );

endinterface

// File: rtl/mmu_arb_tag_fifo.sv
// In-order 1-bit source-tag FIFO; head is read combinationally so a
// response can be routed in the same cycle it arrives.
module mmu_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        data_i,
    output logic        data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge iCLOCK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mmu_req_arbiter.sv
// Shares the MMU logic-request port between fetch and load/store and sequences
// TLB flushes. Define MMU_ARB_ROUND_ROBIN_EN for round-robin contested grants.
module mmu_req_arbiter
    import mmu_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING   = 4,
    parameter int OUTSTANDING_W = 2
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    mmu_req_arbiter_if.slave  bus
);

    arb_state_e             state_q;
    logic                   flash_q;
    logic                   done_q;
    logic                   err_q;

    logic                   fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OUTSTANDING_W:0] fifo_count;

    logic                   pop;
    logic                   can_grant;
    logic                   ls_wins;
    logic                   grant_if;
    logic                   grant_ls;

    assign pop = bus.iMMU_VALID && !fifo_empty;

    // A flush request in RUN suppresses grants in that same cycle
    assign can_grant = (state_q == STT_RUN) && !bus.iTLB_FLUSH_REQ &&
                       !bus.iMMU_LOCK && (!fifo_full || pop);

`ifdef MMU_ARB_ROUND_ROBIN_EN
    logic rr_q;

    assign ls_wins = (rr_q == ARB_TAG_LS);

    // Only contested grants move the pointer, and always to the loser
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rr_q <= ARB_TAG_IF;
        end else if (can_grant && bus.iIF_REQ && bus.iLS_REQ) begin
            rr_q <= grant_ls ? ARB_TAG_IF : ARB_TAG_LS;
        end
    end
`else
    assign ls_wins = 1'b1;
`endif

    assign grant_ls = can_grant && bus.iLS_REQ && (!bus.iIF_REQ || ls_wins);
    assign grant_if = can_grant && bus.iIF_REQ && !grant_ls;

    assign bus.oIF_LOCK = (bus.iIF_REQ && !grant_if) || bus.iMMU_LOCK || (state_q != STT_RUN);
    assign bus.oLS_LOCK = (bus.iLS_REQ && !grant_ls) || bus.iMMU_LOCK || (state_q != STT_RUN);

    always_comb begin
        bus.oMMU_REQ = grant_if || grant_ls;
        if (grant_ls) begin
            bus.oMMU_DATA_STORE_ACK = bus.iLS_DATA_STORE_ACK;
            bus.oMMU_MODE           = bus.iLS_MODE;
            bus.oMMU_PDT            = bus.iLS_PDT;
            bus.oMMU_ORDER          = bus.iLS_ORDER;
            bus.oMMU_RW             = bus.iLS_RW;
            bus.oMMU_ADDR           = bus.iLS_ADDR;
            bus.oMMU_DATA           = bus.iLS_DATA;
        end else begin
            bus.oMMU_DATA_STORE_ACK = 1'b0;
            bus.oMMU_MODE           = bus.iIF_MODE;
            bus.oMMU_PDT            = bus.iIF_PDT;
            bus.oMMU_ORDER          = ARB_IF_ORDER;
            bus.oMMU_RW             = 1'b0;
            bus.oMMU_ADDR           = bus.iIF_ADDR;
            bus.oMMU_DATA           = 32'h0;
        end
    end

    mmu_arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .AW    (OUTSTANDING_W)
    ) u_tag_fifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .push_i  (grant_if || grant_ls),
        .pop_i   (pop),
        .data_i  (grant_ls ? ARB_TAG_LS : ARB_TAG_IF),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.oIF_VALID  = pop && (fifo_head == ARB_TAG_IF);
    assign bus.oLS_VALID  = pop && (fifo_head == ARB_TAG_LS);
    assign bus.oRESP_DATA = bus.iMMU_DATA;

    // Flush merges: requests seen outside RUN are absorbed by the current flush
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= STT_RUN;
            flash_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.iMMU_VALID && fifo_empty) begin
                err_q <= 1'b1;
            end
            case (state_q)
                STT_RUN: begin
                    if (bus.iTLB_FLUSH_REQ) begin
                        state_q <= STT_DRAIN;
                    end
                end
                STT_DRAIN: begin
                    if ((fifo_count == '0) && !bus.iMMU_LOCK) begin
                        state_q <= STT_FLASH;
                        flash_q <= 1'b1;
                    end
                end
                STT_FLASH: begin
                    state_q <= STT_RUN;
                    flash_q <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= STT_RUN;
                    flash_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oMMU_TLB_FLASH  = flash_q;
    assign bus.oTLB_FLUSH_DONE = done_q;
    assign bus.oPROTOCOL_ERR   = err_q;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Cycle-vector bench for mmu_req_arbiter: table of per-cycle stimulus and
// expected outputs, plus hand sequences for reset and contested arbitration.
module tb_mmu_req_arbiter;

    localparam logic [31:0] IFA = 32'h0000_2000;
    localparam logic [31:0] LSA = 32'h0000_1000;

    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;

    mmu_req_arbiter_if u_if ();

    mmu_req_arbiter #(
        .OUTSTANDING   (4),
        .OUTSTANDING_W (2)
    ) dut (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .bus     (u_if)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic        ifr, lsr, lock, val, flush;
        logic [63:0] vdata;
        logic        req;
        logic [31:0] addr;
        logic        ifl, lsl, ifv, lsv, fl, dn, er;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic ifr, input logic lsr, input logic lock, input logic val,
                       input logic flush, input logic [63:0] vd, input logic req,
                       input logic [31:0] addr, input logic ifl, input logic lsl,
                       input logic ifv, input logic lsv, input logic fl, input logic dn,
                       input logic er);
        vec_t v;
        v.ifr = ifr; v.lsr = lsr; v.lock = lock; v.val = val; v.flush = flush;
        v.vdata = vd; v.req = req; v.addr = addr; v.ifl = ifl; v.lsl = lsl;
        v.ifv = ifv; v.lsv = lsv; v.fl = fl; v.dn = dn; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ifr, input logic lsr, input logic lock, input logic val,
                         input logic flush, input logic [63:0] vd);
        u_if.iIF_REQ        = ifr;
        u_if.iLS_REQ        = lsr;
        u_if.iMMU_LOCK      = lock;
        u_if.iMMU_VALID     = val;
        u_if.iTLB_FLUSH_REQ = flush;
        u_if.iMMU_DATA      = vd;
    endtask

    task automatic check_grant(input int cyc, input logic [31:0] addr);
        logic is_ls;
        is_ls = (addr == LSA);
        chk("mmu_addr", cyc, 64'(u_if.oMMU_ADDR), 64'(addr));
        chk("mmu_rw", cyc, 64'(u_if.oMMU_RW), 64'(is_ls));
        chk("mmu_order", cyc, 64'(u_if.oMMU_ORDER), is_ls ? 64'h1 : 64'h2);
        chk("mmu_data", cyc, 64'(u_if.oMMU_DATA), is_ls ? 64'hDEAD_BEEF : 64'h0);
        chk("mmu_ack", cyc, 64'(u_if.oMMU_DATA_STORE_ACK), 64'(is_ls));
        chk("mmu_pdt", cyc, 64'(u_if.oMMU_PDT), is_ls ? 64'hAAAA_0000 : 64'hBBBB_0000);
    endtask

    task automatic apply(input vec_t v, input int cyc);
        @(negedge iCLOCK);
        drive(v.ifr, v.lsr, v.lock, v.val, v.flush, v.vdata);
        #2;
        chk("mmu_req", cyc, 64'(u_if.oMMU_REQ), 64'(v.req));
        if (v.req) check_grant(cyc, v.addr);
        chk("if_lock", cyc, 64'(u_if.oIF_LOCK), 64'(v.ifl));
        chk("ls_lock", cyc, 64'(u_if.oLS_LOCK), 64'(v.lsl));
        chk("if_valid", cyc, 64'(u_if.oIF_VALID), 64'(v.ifv));
        chk("ls_valid", cyc, 64'(u_if.oLS_VALID), 64'(v.lsv));
        if (v.ifv || v.lsv) chk("resp_data", cyc, u_if.oRESP_DATA, v.vdata);
        chk("tlb_flash", cyc, 64'(u_if.oMMU_TLB_FLASH), 64'(v.fl));
        chk("flush_done", cyc, 64'(u_if.oTLB_FLUSH_DONE), 64'(v.dn));
        chk("proto_err", cyc, 64'(u_if.oPROTOCOL_ERR), 64'(v.er));
        $display("cycle %0d ifr=%b lsr=%b lock=%b val=%b flush=%b -> req=%b addr=%h ifv=%b lsv=%b flash=%b done=%b err=%b",
                 cyc, v.ifr, v.lsr, v.lock, v.val, v.flush, u_if.oMMU_REQ, u_if.oMMU_ADDR,
                 u_if.oIF_VALID, u_if.oLS_VALID, u_if.oMMU_TLB_FLASH, u_if.oTLB_FLUSH_DONE,
                 u_if.oPROTOCOL_ERR);
    endtask

    initial begin
        logic       prev_ls;
        logic       exp_ls;
        logic [31:0] exp_addr;

        u_if.iIF_MODE = 2'h3;
        u_if.iIF_PDT  = 32'hBBBB_0000;
        u_if.iIF_ADDR = IFA;
        u_if.iLS_DATA_STORE_ACK = 1'b1;
        u_if.iLS_MODE  = 2'h1;
        u_if.iLS_PDT   = 32'hAAAA_0000;
        u_if.iLS_ORDER = 2'h1;
        u_if.iLS_RW    = 1'b1;
        u_if.iLS_ADDR  = LSA;
        u_if.iLS_DATA  = 32'hDEAD_BEEF;
        drive(0, 0, 1, 0, 0, 64'h0);

        // Reset values, locks follow iMMU_LOCK
        #12;
        chk("rst_if_lock_hi", -1, 64'(u_if.oIF_LOCK), 64'h1);
        chk("rst_ls_lock_hi", -1, 64'(u_if.oLS_LOCK), 64'h1);
        u_if.iMMU_LOCK = 1'b0;
        #1;
        chk("rst_if_lock_lo", -1, 64'(u_if.oIF_LOCK), 64'h0);
        chk("rst_ls_lock_lo", -1, 64'(u_if.oLS_LOCK), 64'h0);
        chk("rst_mmu_req", -1, 64'(u_if.oMMU_REQ), 64'h0);
        chk("rst_flash", -1, 64'(u_if.oMMU_TLB_FLASH), 64'h0);
        chk("rst_done", -1, 64'(u_if.oTLB_FLUSH_DONE), 64'h0);
        chk("rst_err", -1, 64'(u_if.oPROTOCOL_ERR), 64'h0);
        @(negedge iCLOCK);
        inRESET = 1'b1;

`ifdef MMU_ARB_ROUND_ROBIN_EN
        add(1,1,0,0,0,64'h0,        1,IFA, 0,1,0,0, 0,0,0);
        add(0,1,0,0,0,64'h0,        1,LSA, 0,0,0,0, 0,0,0);
        add(0,0,0,1,0,64'hA0A0_0001, 0,0,  0,0,1,0, 0,0,0);
        add(0,0,0,1,0,64'hB0B0_0002, 0,0,  0,0,0,1, 0,0,0);
`else
        add(1,1,0,0,0,64'h0,        1,LSA, 1,0,0,0, 0,0,0);
        add(1,0,0,0,0,64'h0,        1,IFA, 0,0,0,0, 0,0,0);
        add(0,0,0,1,0,64'hA0A0_0001, 0,0,  0,0,0,1, 0,0,0);
        add(0,0,0,1,0,64'hB0B0_0002, 0,0,  0,0,1,0, 0,0,0);
`endif
        for (int k = 0; k < 3; k++) add(1,0,1,0,0,64'h0, 0,0, 1,1,0,0, 0,0,0);
        add(1,0,0,0,0,64'h0,        1,IFA, 0,0,0,0, 0,0,0);
        add(0,0,0,1,0,64'hC0C0_0003, 0,0,  0,0,1,0, 0,0,0);
        for (int k = 0; k < 4; k++) add(0,1,0,0,0,64'h0, 1,LSA, 0,0,0,0, 0,0,0);
        add(0,1,0,0,0,64'h0,        0,0,   0,1,0,0, 0,0,0);
        add(0,1,0,1,0,64'hD0D0_0004, 1,LSA, 0,0,0,1, 0,0,0);
        add(0,1,0,0,0,64'h0,        0,0,   0,1,0,0, 0,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,1,0,64'hE0E0_0010 + 64'(k), 0,0, 0,0,0,1, 0,0,0);
        add(1,0,0,0,0,64'h0,        1,IFA, 0,0,0,0, 0,0,0);
        add(0,1,0,0,0,64'h0,        1,LSA, 0,0,0,0, 0,0,0);
        add(1,0,0,0,1,64'h0,        0,0,   1,0,0,0, 0,0,0);
        add(1,0,0,0,1,64'h0,        0,0,   1,1,0,0, 0,0,0);
        add(1,0,0,1,0,64'hF0F0_0001, 0,0,  1,1,1,0, 0,0,0);
        add(1,0,0,1,0,64'hF0F0_0002, 0,0,  1,1,0,1, 0,0,0);
        add(1,0,0,0,0,64'h0,        0,0,   1,1,0,0, 0,0,0);
        add(1,0,0,0,0,64'h0,        0,0,   1,1,0,0, 1,0,0);
        add(1,0,0,0,0,64'h0,        1,IFA, 0,0,0,0, 0,1,0);
        add(0,0,0,1,0,64'h9090_0005, 0,0,  0,0,1,0, 0,0,0);
        add(0,0,0,1,0,64'h8080_0006, 0,0,  0,0,0,0, 0,0,0);
        add(0,0,0,0,0,64'h0,        0,0,   0,0,0,0, 0,0,1);
        add(0,0,0,0,0,64'h0,        0,0,   0,0,0,0, 0,0,1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset with one access in flight: state clears, late response is an error
        @(negedge iCLOCK);
        drive(1, 0, 0, 0, 0, 64'h0);
        #2;
        chk("pre_rst_grant", 100, 64'(u_if.oMMU_REQ), 64'h1);
        @(negedge iCLOCK);
        drive(0, 0, 0, 0, 0, 64'h0);
        inRESET = 1'b0;
        #2;
        chk("mid_rst_err", 101, 64'(u_if.oPROTOCOL_ERR), 64'h0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        drive(0, 0, 0, 1, 0, 64'h77);
        #2;
        chk("late_resp_ifv", 102, 64'(u_if.oIF_VALID), 64'h0);
        chk("late_resp_lsv", 102, 64'(u_if.oLS_VALID), 64'h0);
        @(negedge iCLOCK);
        drive(0, 0, 0, 0, 0, 64'h0);
        #2;
        chk("late_resp_err", 103, 64'(u_if.oPROTOCOL_ERR), 64'h1);
        $display("cycle 103 reset-in-flight err=%b", u_if.oPROTOCOL_ERR);
        @(negedge iCLOCK);
        inRESET = 1'b0;
        @(negedge iCLOCK);
        inRESET = 1'b1;

        // Both requesting continuously for six grants, responses streaming back
        prev_ls = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge iCLOCK);
            drive(k < 6, k < 6, 0, k > 0, 0, 64'h5000 + 64'(k));
            #2;
`ifdef MMU_ARB_ROUND_ROBIN_EN
            exp_ls = (k % 2) == 1;
`else
            exp_ls = 1'b1;
`endif
            exp_addr = exp_ls ? LSA : IFA;
            if (k < 6) begin
                chk("arb_req", 200 + k, 64'(u_if.oMMU_REQ), 64'h1);
                chk("arb_addr", 200 + k, 64'(u_if.oMMU_ADDR), 64'(exp_addr));
            end
            if (k > 0) begin
                chk("arb_ifv", 200 + k, 64'(u_if.oIF_VALID), 64'(!prev_ls));
                chk("arb_lsv", 200 + k, 64'(u_if.oLS_VALID), 64'(prev_ls));
                chk("arb_data", 200 + k, u_if.oRESP_DATA, 64'h5000 + 64'(k));
            end
            $display("cycle %0d arb req=%b addr=%h ifv=%b lsv=%b", 200 + k, u_if.oMMU_REQ,
                     u_if.oMMU_ADDR, u_if.oIF_VALID, u_if.oLS_VALID);
            prev_ls = exp_ls;
        end
        @(negedge iCLOCK);
        drive(0, 0, 0, 0, 0, 64'h0);
        #2;
        chk("arb_err_clear", 207, 64'(u_if.oPROTOCOL_ERR), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
